// File: rtl/fb_cmd_parser.sv
// Packet command parser feeding the frame-buffer write port: streamed data with
// auto-increment, address set, and run-length fill with decoder back-pressure.
module fb_cmd_parser #(
  parameter int unsigned ADDR_W    = 16,
  parameter logic [7:0]  MODE_DATA = 8'h01,
  parameter logic [7:0]  MODE_ADDR = 8'h02,
  parameter logic [7:0]  MODE_FILL = 8'h03
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sync,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              busy,
  output logic              err
);

  typedef enum logic [3:0] {
    S_MODE, S_DATA, S_ADDR_LO, S_ADDR_HI,
    S_FILL_CLO, S_FILL_CHI, S_FILL_VAL, S_FILL_RUN, S_SKIP
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [7:0]          addr_lo_q, addr_lo_d;
  logic [7:0]          val_q, val_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]          wr_data_q, wr_data_d;
  logic                busy_q, busy_d;
  logic                err_q, err_d;
  logic                accept_s;

  assign in_ready = rst && !sync && (state_q != S_FILL_RUN);
  assign accept_s = in_valid && in_ready;

  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign busy    = busy_q;
  assign err     = err_q;

  // Next-state and write-port decode; the first fill write is issued with the value byte.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    addr_lo_d = addr_lo_q;
    val_d     = val_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    err_d     = err_q;
    if (sync) begin
      state_d = S_MODE;
    end else if (state_q == S_FILL_RUN) begin
      // cnt_q holds the writes still to issue after the one currently on the port
      if (cnt_q != {ADDR_W{1'b0}}) begin
        wr_en_d   = 1'b1;
        wr_addr_d = ptr_q;
        wr_data_d = val_q;
        ptr_d     = ptr_q + ADDR_W'(1);
        cnt_d     = cnt_q - ADDR_W'(1);
      end else begin
        state_d = S_MODE;
      end
    end else if (accept_s) begin
      case (state_q)
        S_MODE: begin
          case (in_data)
            MODE_DATA: state_d = S_DATA;
            MODE_ADDR: state_d = S_ADDR_LO;
            MODE_FILL: state_d = S_FILL_CLO;
            default: begin
              state_d = S_SKIP;
              err_d   = 1'b1;
            end
          endcase
        end
        S_DATA: begin
          wr_en_d   = 1'b1;
          wr_addr_d = ptr_q;
          wr_data_d = in_data;
          ptr_d     = ptr_q + ADDR_W'(1);
        end
        S_ADDR_LO: begin
          addr_lo_d = in_data;
          state_d   = S_ADDR_HI;
        end
        S_ADDR_HI: begin
          ptr_d   = ADDR_W'({in_data, addr_lo_q});
          state_d = S_ADDR_LO;
        end
        S_FILL_CLO: begin
          cnt_d   = ADDR_W'(in_data);
          state_d = S_FILL_CHI;
        end
        S_FILL_CHI: begin
          cnt_d   = ADDR_W'({in_data, cnt_q[7:0]});
          state_d = S_FILL_VAL;
        end
        S_FILL_VAL: begin
          val_d = in_data;
          if (cnt_q == {ADDR_W{1'b0}}) begin
            state_d = S_MODE;
          end else begin
            wr_en_d   = 1'b1;
            wr_addr_d = ptr_q;
            wr_data_d = in_data;
            ptr_d     = ptr_q + ADDR_W'(1);
            cnt_d     = cnt_q - ADDR_W'(1);
            state_d   = S_FILL_RUN;
          end
        end
        S_SKIP:  state_d = S_SKIP;
        default: state_d = S_MODE;
      endcase
    end else begin
      state_d = state_q;
    end
    busy_d = (state_d == S_FILL_RUN);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_MODE;
      ptr_q     <= {ADDR_W{1'b0}};
      cnt_q     <= {ADDR_W{1'b0}};
      addr_lo_q <= 8'h00;
      val_q     <= 8'h00;
      wr_en_q   <= 1'b0;
      wr_addr_q <= {ADDR_W{1'b0}};
      wr_data_q <= 8'h00;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      addr_lo_q <= addr_lo_d;
      val_q     <= val_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_fb_cmd_parser.sv
// Bench for fb_cmd_parser: directed packets then random traffic, checked every
// cycle against a byte-level command model.
module tb_fb_cmd_parser;

  logic        clk;
  logic        rst;
  logic        sync;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        wr_en;
  logic [15:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: command byte of the packet and how many argument bytes followed it.
  logic        m_have;
  logic [7:0]  m_cmd;
  int          m_idx;
  logic [15:0] m_ptr;
  logic [7:0]  m_lo;
  int          m_cnt;
  logic [7:0]  m_val;
  int          m_run;
  logic        m_fillw;
  logic        m_err;
  logic        e_wr_en;
  logic [15:0] e_addr;
  logic [7:0]  e_data;

  fb_cmd_parser dut (
    .clk(clk), .rst(rst), .sync(sync), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [7:0] d);
    e_wr_en = 1'b1;
    e_addr  = m_ptr;
    e_data  = d;
    m_ptr   = m_ptr + 16'd1;
  endtask

  task automatic model_edge(input logic r, input logic s, input logic v, input logic [7:0] d);
    if (!r) begin
      m_have = 1'b0; m_cmd = 8'h00; m_idx = 0; m_ptr = 16'h0000; m_lo = 8'h00;
      m_cnt = 0; m_val = 8'h00; m_run = 0; m_fillw = 1'b0; m_err = 1'b0;
      e_wr_en = 1'b0; e_addr = 16'h0000; e_data = 8'h00;
    end else if (s) begin
      m_have = 1'b0; m_fillw = 1'b0; m_run = 0; e_wr_en = 1'b0;
    end else if (m_fillw) begin
      if (m_run > 0) begin
        issue(m_val);
        m_run--;
      end else begin
        m_fillw = 1'b0; m_have = 1'b0; e_wr_en = 1'b0;
      end
    end else begin
      e_wr_en = 1'b0;
      if (v) begin
        if (!m_have) begin
          m_have = 1'b1; m_cmd = d; m_idx = 0;
          if (d != 8'h01 && d != 8'h02 && d != 8'h03) m_err = 1'b1;
        end else begin
          case (m_cmd)
            8'h01: issue(d);
            8'h02: begin
              if (m_idx % 2 == 0) m_lo = d;
              else m_ptr = {d, m_lo};
            end
            8'h03: begin
              if (m_idx == 0) m_cnt = int'(d);
              else if (m_idx == 1) m_cnt = m_cnt + 256 * int'(d);
              else begin
                m_val = d;
                if (m_cnt == 0) m_have = 1'b0;
                else begin
                  issue(d);
                  m_run = m_cnt - 1;
                  m_fillw = 1'b1;
                end
              end
            end
            default: ;
          endcase
          m_idx++;
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic s, input logic v, input logic [7:0] d);
    @(negedge clk);
    rst = r; sync = s; in_valid = v; in_data = d;
    #1;
    chk("in_ready", 32'(in_ready), 32'(r && !s && !m_fillw));
    @(posedge clk);
    model_edge(r, s, v, d);
    #1;
    chk("wr_en", 32'(wr_en), 32'(e_wr_en));
    chk("wr_addr", 32'(wr_addr), 32'(e_addr));
    chk("wr_data", 32'(wr_data), 32'(e_data));
    chk("busy", 32'(busy), 32'(m_fillw));
    chk("err", 32'(err), 32'(m_err));
  endtask

  task automatic pkt_sync();
    step(1'b1, 1'b1, 1'b0, 8'h00);
  endtask

  task automatic byte_in(input logic [7:0] d);
    step(1'b1, 1'b0, 1'b1, d);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 8'h00);
  endtask

  int fill_writes;
  int busy_cycles;

  initial begin
    rst = 1'b0; sync = 1'b0; in_valid = 1'b0; in_data = 8'h00;
    model_edge(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b0, 1'b1, 8'h01);

    // address then data
    pkt_sync(); byte_in(8'h02); byte_in(8'h34); byte_in(8'h12);
    pkt_sync(); byte_in(8'h01); byte_in(8'hAA); byte_in(8'hBB); byte_in(8'hCC); idle(2);
    // wrap at the top of the address space
    pkt_sync(); byte_in(8'h02); byte_in(8'hFE); byte_in(8'hFF);
    pkt_sync(); byte_in(8'h01); byte_in(8'h11); byte_in(8'h22); byte_in(8'h33); idle(1);
    // five-write fill at 0x0100, counting writes and busy cycles independently
    pkt_sync(); byte_in(8'h02); byte_in(8'h00); byte_in(8'h01);
    pkt_sync(); byte_in(8'h03); byte_in(8'h05); byte_in(8'h00); byte_in(8'h7E);
    fill_writes = (wr_en === 1'b1) ? 1 : 0;
    busy_cycles = (busy === 1'b1) ? 1 : 0;
    for (int i = 0; i < 7; i++) begin
      idle(1);
      if (wr_en === 1'b1) fill_writes++;
      if (busy === 1'b1) busy_cycles++;
    end
    chk("fill5_writes", 32'(fill_writes), 32'd5);
    chk("fill5_busy", 32'(busy_cycles), 32'd5);
    chk("fill5_last_addr", 32'(wr_addr), 32'h0104);
    // zero count, then fill of 3 followed by a data byte in the same packet
    pkt_sync(); byte_in(8'h03); byte_in(8'h00); byte_in(8'h00); byte_in(8'h99); idle(2);
    pkt_sync(); byte_in(8'h02); byte_in(8'h00); byte_in(8'h02);
    pkt_sync(); byte_in(8'h03); byte_in(8'h03); byte_in(8'h00); byte_in(8'h99); idle(3);
    byte_in(8'h01); byte_in(8'h55);
    chk("after_fill_addr", 32'(wr_addr), 32'h0203);
    // abort a 10-write fill with sync during its second write
    pkt_sync(); byte_in(8'h03); byte_in(8'h0A); byte_in(8'h00); byte_in(8'h44);
    idle(1); pkt_sync(); idle(3);
    // sync with a valid byte drops it
    step(1'b1, 1'b1, 1'b1, 8'h09); byte_in(8'h01); byte_in(8'h66); idle(1);
    // unknown mode, then reset in the middle of a data packet
    pkt_sync(); byte_in(8'h09); byte_in(8'h01); byte_in(8'h77); pkt_sync(); idle(1);
    byte_in(8'h01); byte_in(8'h10); byte_in(8'h20); step(1'b0, 1'b0, 1'b1, 8'h30);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    // fill aborted by reset
    pkt_sync(); byte_in(8'h03); byte_in(8'h08); byte_in(8'h00); byte_in(8'h5A); idle(1);
    step(1'b0, 1'b0, 1'b0, 8'h00); idle(2);

    // random traffic, mode bytes biased toward valid commands
    for (int i = 0; i < 3000; i++) begin
      logic s, v, r;
      logic [7:0] d;
      r = ($urandom_range(0, 499) != 0);
      s = ($urandom_range(0, 24) == 0);
      v = ($urandom_range(0, 3) != 0);
      d = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 4)) : 8'($urandom_range(0, 255));
      step(r, s, v, d);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fb_cmd_parser.md
Name: fb_cmd_parser

Overview:
- Command parser between the COBS decoder and the frame buffer write port.
- Consumes the decoded byte stream of each packet and turns it into frame-buffer writes: streamed data with auto-increment, address set, and run-length fill.
- Drives the write port (wr_en/wr_addr/wr_data) of the 64 KiB 8-bit frame buffer.
- Throttles the decoder with a valid/ready handshake during fills.

Parameters:
- ADDR_W, 16, frame-buffer address width; also the fill count width.
- MODE_DATA, 8'h01, mode byte selecting data streaming.
- MODE_ADDR, 8'h02, mode byte selecting address set.
- MODE_FILL, 8'h03, mode byte selecting run-length fill.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous reset, active-low (one clock; reset is synchronous and active-low).
- sync  in  1  packet-delimiter pulse from the decoder (zero byte seen).
- in_valid  in  1  decoded byte available.
- in_data  in  8  decoded byte.
- in_ready  out  1  byte accepted when in_valid && in_ready.
- wr_en  out  1  frame-buffer write strobe, one cycle per write.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  8  write data.
- busy  out  1  high while a fill is running.
- err  out  1  sticky: unknown mode byte received.

Behaviour:
- Reset (rst=0 at posedge):
  - state=MODE; wr_en=0, wr_addr=0, wr_data=0, busy=0, err=0.
  - Internal ptr=0, cnt=0, addr_lo=0.
- Handshake:
  - in_ready = rst && !sync && state!=FILL_RUN. This is combinational on sync.
  - A byte is accepted only on in_valid && in_ready.
- States: MODE, DATA, ADDR_LO, ADDR_HI, FILL_CLO, FILL_CHI, FILL_VAL, FILL_RUN, SKIP.
- sync=1: next state=MODE from any state, including FILL_RUN, which aborts the fill.
  - wr_en=0 in the following cycle.
  - ptr is kept.
  - sync takes priority over a simultaneous in_valid; that byte is dropped.
- MODE, on an accepted byte:
  - MODE_DATA -> DATA; MODE_ADDR -> ADDR_LO; MODE_FILL -> FILL_CLO.
  - Any other value -> SKIP and err<=1.
- DATA, per accepted byte b:
  - Next cycle: wr_en=1, wr_addr=ptr, wr_data=b; ptr<=ptr+1.
  - Stays in DATA until sync. Back-to-back bytes give back-to-back writes.
- ADDR_LO: addr_lo<=b; -> ADDR_HI.
- ADDR_HI: ptr<={b,addr_lo} (committed atomically on this byte); -> ADDR_LO.
  - Repeated address pairs are allowed until sync.
- FILL_CLO / FILL_CHI: capture cnt low and high byte, in that order.
- FILL_VAL: capture value v.
  - cnt==0: -> MODE, no writes.
  - Otherwise: -> FILL_RUN, busy=1.
- FILL_RUN: one write per cycle (wr_en=1, wr_addr=ptr, wr_data=v); ptr++, cnt--.
  - After the cnt-th write: -> MODE, busy=0.
  - Exactly cnt writes, first write in the cycle after the value byte is accepted.
- SKIP: accepts and discards bytes until sync.
- wr_en outside the cases above is 0. wr_addr and wr_data hold their last values.
- Address arithmetic is mod 2^ADDR_W: ptr wraps 0xFFFF -> 0x0000 in both DATA and FILL.
- err is cleared only by reset.
- Reset mid-fill: immediate return to reset values, no further writes.

Test Plan:
- Address then data: sync, 02 34 12, sync, 01 AA BB CC -> writes (0x1234,AA),(0x1235,BB),(0x1236,CC), one cycle after each accept; no other wr_en.
- Wrap: address 0xFFFE, then DATA 11 22 33 -> writes at 0xFFFE, 0xFFFF, 0x0000.
- Fill: ptr=0x0100, 03 05 00 7E -> 5 consecutive writes 0x0100..0x0104 of 7E; busy high exactly 5 cycles; in_ready=0 during those cycles; then MODE.
- Fill edge cases: count 0000 -> no write, busy stays 0. Fill 0x0003 followed by DATA byte 55 -> 55 written at ptr+3.
- Abort and priority: sync pulsed during the 2nd cycle of a 10-write fill -> exactly 1 or 2 writes per cycle boundary as specified, busy=0 next cycle. sync together with in_valid -> byte dropped.
- Error and reset: mode byte 09 -> err=1, following bytes produce no writes until sync; rst=0 mid-DATA -> all outputs return to reset values next cycle.
